// File: rtl/shru_save_ctrl_pkg.sv
// Shared types and constants for the shadow-register save controller.
package shru_save_ctrl_pkg;

    localparam int SHRU_NR_WORDS = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        STORE = 1'b1
    } shru_state_e;

    // Slot of each context word within save_data_i
    typedef enum logic [1:0] {
        WORD_MEPC   = 2'd0,
        WORD_MCAUSE = 2'd1,
        WORD_SP     = 2'd2,
        WORD_RA     = 2'd3
    } shru_word_e;

endpackage

// File: rtl/shru_offset_cmp.sv
// Flags when a load page offset aliases any save word not yet granted.
// Works on word-granular offset bits; the stride is one word, so line j is base+j.
module shru_offset_cmp #(
    parameter int NR_WORDS = 4,
    parameter int IDX_W    = $clog2(NR_WORDS + 1),
    parameter int OFF_W    = 9
) (
    input  logic [OFF_W-1:0] base_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [OFF_W-1:0] page_offset_i,
    output logic             match_o
);

    logic [OFF_W-1:0] word_off [NR_WORDS];

    for (genvar j = 0; j < NR_WORDS; j++) begin : g_off
        assign word_off[j] = base_i + OFF_W'(j);
    end

    always_comb begin
        match_o = 1'b0;
        for (int j = 0; j < NR_WORDS; j++) begin
            if ((IDX_W'(j) >= idx_i) && (word_off[j] == page_offset_i)) begin
                match_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shru_save_ctrl.sv
// Shadow-register save sequencer: snapshots context words on a trigger and
// streams them as stores below the incoming stack pointer via a req/gnt port.
module shru_save_ctrl
    import shru_save_ctrl_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int NR_WORDS   = SHRU_NR_WORDS,
    parameter int WORD_BYTES = XLEN / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     save_i,
    input  logic [NR_WORDS*XLEN-1:0] save_data_i,
    input  logic [XLEN-1:0]          sp_i,
    output logic                     ready_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overrun_o,
    output logic [XLEN-1:0]          next_sp_o,
    output logic                     dreq_valid_o,
    output logic [XLEN-1:0]          dreq_addr_o,
    output logic [XLEN-1:0]          dreq_data_o,
    output logic [WORD_BYTES-1:0]    dreq_be_o,
    input  logic                     dreq_gnt_i,
    input  logic [11:0]              page_offset_i,
    output logic                     page_offset_match_o
);

    localparam int              IDX_W       = $clog2(NR_WORDS + 1);
    localparam int              OFF_LSB     = $clog2(WORD_BYTES);
    localparam int              OFF_W       = 12 - OFF_LSB;
    localparam logic [XLEN-1:0] FRAME_BYTES = XLEN'(NR_WORDS * WORD_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NR_WORDS - 1);

    shru_state_e              state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NR_WORDS*XLEN-1:0] snap_q, snap_d;
    logic [XLEN-1:0]          next_sp_q, next_sp_d;
    logic                     done_q, done_d;
    logic                     overrun_q, overrun_d;
    logic                     cmp_match;
    logic                     unused_offset_lsbs;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            snap_q    <= '0;
            next_sp_q <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            next_sp_q <= next_sp_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        next_sp_d = next_sp_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (save_i) begin
                    snap_d    = save_data_i;
                    next_sp_d = sp_i - FRAME_BYTES;
                    idx_d     = '0;
                    state_d   = STORE;
                end
            end
            STORE: begin
                // A trigger mid-save is dropped; the snapshot stays untouched
                if (save_i) begin
                    overrun_d = 1'b1;
                end
                if (dreq_gnt_i) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o       = (state_q == STORE);
    assign ready_o      = ~busy_o;
    assign done_o       = done_q;
    assign overrun_o    = overrun_q;
    assign next_sp_o    = next_sp_q;
    assign dreq_valid_o = busy_o;
    assign dreq_addr_o  = next_sp_q + XLEN'(idx_q) * XLEN'(WORD_BYTES);
    assign dreq_data_o  = snap_q[int'(idx_q)*XLEN +: XLEN];
    assign dreq_be_o    = '1;

    // Byte lanes inside a word cannot distinguish aliasing words
    assign unused_offset_lsbs = ^page_offset_i[OFF_LSB-1:0];

    shru_offset_cmp #(
        .NR_WORDS(NR_WORDS),
        .IDX_W   (IDX_W),
        .OFF_W   (OFF_W)
    ) u_offset_cmp (
        .base_i       (next_sp_q[11:OFF_LSB]),
        .idx_i        (idx_q),
        .page_offset_i(page_offset_i[11:OFF_LSB]),
        .match_o      (cmp_match)
    );

    assign page_offset_match_o = busy_o & cmp_match;

endmodule

// File: tb/tb_shru_save_ctrl.sv
// Directed bench for shru_save_ctrl with a queue-based store model checked every cycle.
module tb_shru_save_ctrl;
    import shru_save_ctrl_pkg::*;

    localparam int XLEN = 64;
    localparam int NR   = 4;
    localparam int WB   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              save_i = 1'b0;
    logic [NR*XLEN-1:0] save_data = '0;
    logic [XLEN-1:0]   sp = '0;
    logic              gnt = 1'b0;
    logic [11:0]       po = 12'h000;

    logic              ready_o, busy_o, done_o, overrun_o, dreq_valid_o, match_o;
    logic [XLEN-1:0]   next_sp_o, dreq_addr_o, dreq_data_o;
    logic [WB-1:0]     dreq_be_o;

    always #5 clk = ~clk;

    shru_save_ctrl #(.XLEN(XLEN), .NR_WORDS(NR)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .save_i             (save_i),
        .save_data_i        (save_data),
        .sp_i               (sp),
        .ready_o            (ready_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .overrun_o          (overrun_o),
        .next_sp_o          (next_sp_o),
        .dreq_valid_o       (dreq_valid_o),
        .dreq_addr_o        (dreq_addr_o),
        .dreq_data_o        (dreq_data_o),
        .dreq_be_o          (dreq_be_o),
        .dreq_gnt_i         (gnt),
        .page_offset_i      (po),
        .page_offset_match_o(match_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int grants = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an accepted save becomes a list of pending stores; each grant retires one
    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } store_t;

    store_t      exp_q[$];
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_ovr  = 1'b0;
    logic [63:0] m_next_sp = '0;

    function automatic logic model_match(input logic [11:0] off);
        logic m;
        m = 1'b0;
        foreach (exp_q[i]) begin
            if (exp_q[i].addr[11:3] == off[11:3]) m = 1'b1;
        end
        return m_busy && m;
    endfunction

    // Inputs change only just after a rising edge, so values seen here are
    // those the next rising edge samples.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_busy    = 1'b0;
                m_done    = 1'b0;
                m_ovr     = 1'b0;
                m_next_sp = '0;
            end else begin
                chk("busy", busy_o, m_busy);
                chk("ready", ready_o, !m_busy);
                chk("valid", dreq_valid_o, m_busy);
                chk("done", done_o, m_done);
                chk("overrun", overrun_o, m_ovr);
                chk("next_sp", next_sp_o, m_next_sp);
                chk("match", match_o, model_match(po));
                if (m_busy) begin
                    chk("addr", dreq_addr_o, exp_q[0].addr);
                    chk("data", dreq_data_o, exp_q[0].data);
                    chk("be", dreq_be_o, 8'hFF);
                end
                if (dreq_valid_o && gnt) grants++;

                m_done = 1'b0;
                if (m_busy) begin
                    if (save_i) m_ovr = 1'b1;
                    if (gnt) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            m_busy = 1'b0;
                            m_done = 1'b1;
                        end
                    end
                end else if (save_i) begin
                    m_next_sp = sp - 64'(NR * WB);
                    for (int k = 0; k < NR; k++) begin
                        exp_q.push_back('{addr: m_next_sp + 64'(k * WB),
                                          data: save_data[k*XLEN +: XLEN]});
                    end
                    m_busy = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a trigger for one cycle; returns in the first STORE cycle
    task automatic start_save(input logic [63:0] sp_v, input logic [63:0] w0,
                              input logic [63:0] w1, input logic [63:0] w2,
                              input logic [63:0] w3);
        sp = sp_v;
        save_data[int'(WORD_MEPC)*XLEN   +: XLEN] = w0;
        save_data[int'(WORD_MCAUSE)*XLEN +: XLEN] = w1;
        save_data[int'(WORD_SP)*XLEN     +: XLEN] = w2;
        save_data[int'(WORD_RA)*XLEN     +: XLEN] = w3;
        save_i = 1'b1;
        tick();
        save_i = 1'b0;
    endtask

    task automatic wait_done(input string name, inout int cnt);
        while (!done_o && cnt < 20) begin
            tick();
            cnt++;
        end
        if (!done_o) chk({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    logic [63:0] a_basic [4];
    logic [63:0] d_basic [4];
    logic [63:0] a_wrap  [4];

    initial begin
        int cnt;
        a_basic = '{64'h8000_0FE0, 64'h8000_0FE8, 64'h8000_0FF0, 64'h8000_0FF8};
        d_basic = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
                    64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D};
        a_wrap  = '{64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF8,
                    64'h0000_0000_0000_0000, 64'h0000_0000_0000_0008};

        po = 12'hFE0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_valid", dreq_valid_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_overrun", overrun_o, 1'b0);
        chk("rst_next_sp", next_sp_o, 64'h0);
        chk("rst_match", match_o, 1'b0);
        rst = 1'b0;
        tick();

        // Basic save, grant always high
        gnt = 1'b1;
        start_save(64'h8000_1000, d_basic[0], d_basic[1], d_basic[2], d_basic[3]);
        chk("basic_next_sp", next_sp_o, 64'h8000_0FE0);
        for (int k = 0; k < 4; k++) begin
            chk("basic_valid", dreq_valid_o, 1'b1);
            chk("basic_addr", dreq_addr_o, a_basic[k]);
            chk("basic_data", dreq_data_o, d_basic[k]);
            tick();
        end
        chk("basic_done", done_o, 1'b1);
        chk("basic_ready", ready_o, 1'b1);
        chk("basic_idle_valid", dreq_valid_o, 1'b0);
        tick();
        chk("basic_done_pulse", done_o, 1'b0);

        // Backpressure: word 1 waits three cycles
        grants = 0;
        start_save(64'h8000_1000, 64'h1111, 64'h2222, 64'h3333, 64'h4444);
        tick();
        gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_addr_hold", dreq_addr_o, 64'h8000_0FE8);
            chk("bp_data_hold", dreq_data_o, 64'h2222);
            tick();
        end
        gnt = 1'b1;
        cnt = 5;
        wait_done("bp", cnt);
        chk("bp_cycles", 64'(cnt), 64'd8);
        chk("bp_grants", 64'(grants), 64'd4);
        tick();

        // Overrun: trigger while busy, then a fresh trigger in the done cycle
        start_save(64'h8000_2000, 64'h5151, 64'h5252, 64'h5353, 64'h5454);
        tick();
        start_save(64'h7777_0000, 64'hDEAD, 64'hDEAD, 64'hDEAD, 64'hDEAD);
        chk("ovr_set", overrun_o, 1'b1);
        chk("ovr_next_sp_kept", next_sp_o, 64'h8000_1FE0);
        cnt = 3;
        wait_done("ovr1", cnt);
        start_save(64'h9000_0000, 64'h6161, 64'h6262, 64'h6363, 64'h6464);
        chk("ovr_accept_busy", busy_o, 1'b1);
        chk("ovr_accept_sp", next_sp_o, 64'h8FFF_FFE0);
        chk("ovr_accept_data", dreq_data_o, 64'h6161);
        cnt = 1;
        wait_done("ovr2", cnt);
        chk("ovr_sticky", overrun_o, 1'b1);
        tick();

        // Offset aliasing after word 0 is granted
        start_save(64'h8000_1000, 64'hA1, 64'hA2, 64'hA3, 64'hA4);
        tick();
        gnt = 1'b0;
        po = 12'hFE0;
        #1;
        chk("alias_granted", match_o, 1'b0);
        po = 12'hFF0;
        #1;
        chk("alias_pending", match_o, 1'b1);
        po = 12'hFEC;
        #1;
        chk("alias_current", match_o, 1'b1);
        gnt = 1'b1;
        cnt = 2;
        wait_done("alias", cnt);
        tick();
        po = 12'hFF0;
        #1;
        chk("alias_idle", match_o, 1'b0);

        // Stack pointer wrap-around
        start_save(64'h10, 64'hB1, 64'hB2, 64'hB3, 64'hB4);
        chk("wrap_next_sp", next_sp_o, 64'hFFFF_FFFF_FFFF_FFF0);
        for (int k = 0; k < 4; k++) begin
            chk("wrap_addr", dreq_addr_o, a_wrap[k]);
            tick();
        end
        chk("wrap_done", done_o, 1'b1);
        tick();

        // Reset in the middle of a save
        start_save(64'h8000_1000, 64'hC1, 64'hC2, 64'hC3, 64'hC4);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", dreq_valid_o, 1'b0);
        chk("mid_rst_ready", ready_o, 1'b1);
        chk("mid_rst_overrun", overrun_o, 1'b0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("mid_rst_no_done", done_o, 1'b0);
            chk("mid_rst_no_req", dreq_valid_o, 1'b0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shru_save_ctrl.md
Name: shru_save_ctrl

Overview:
- Sequencer for the shadow-register save path between issue and the data cache.
- On a save trigger it snapshots NR_WORDS context words (mepc, mcause, old sp, ...), computes the new stack pointer, and streams the words as stores through one dcache request port using a req/gnt handshake.
- Tells the load unit when a pending save store aliases its page offset, and reports readiness for the next exception.

Parameters:
- XLEN, 64, data/address width in bits.
- NR_WORDS, 4, words stored per save (>=1, <=16).
- WORD_BYTES, XLEN/8, derived; stride between stored words.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- save_i  in  1  save trigger pulse; accepted only when ready_o=1.
- save_data_i  in  NR_WORDS*XLEN  words to save; word k in bits [k*XLEN+:XLEN].
- sp_i  in  XLEN  stack pointer at trigger.
- ready_o  out  1  controller idle; can accept save_i.
- busy_o  out  1  save in progress.
- done_o  out  1  one-cycle pulse after the last store is granted.
- overrun_o  out  1  sticky; save_i seen while ready_o=0.
- next_sp_o  out  XLEN  sp_i - NR_WORDS*WORD_BYTES, registered at accept.
- dreq_valid_o  out  1  store request valid.
- dreq_addr_o  out  XLEN  store address.
- dreq_data_o  out  XLEN  store data.
- dreq_be_o  out  WORD_BYTES  byte enables; all ones.
- dreq_gnt_i  in  1  cache grant.
- page_offset_i  in  12  page offset requested by the load unit.
- page_offset_match_o  out  1  load offset aliases an ungranted save word.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, idx=0, snapshot regs=0.
  - Outputs: next_sp_o=0, done_o=0, overrun_o=0, dreq_valid_o=0, busy_o=0, ready_o=1, page_offset_match_o=0.
  - Reset mid-save aborts immediately; no further requests are issued.
- States: IDLE and STORE.
- IDLE:
  - ready_o=1.
  - save_i=1 registers save_data_i, sp_i and next_sp_o; sets idx=0; moves to STORE.
  - dreq_valid_o rises in the next cycle (latency 1).
- STORE:
  - dreq_valid_o=1.
  - dreq_addr_o = next_sp_o + idx*WORD_BYTES, computed modulo 2^XLEN.
  - dreq_data_o = snapshot word idx.
  - addr/data/be hold stable until granted.
  - dreq_gnt_i=1 with idx<NR_WORDS-1: idx++ and the next word is presented in the next cycle (back-to-back, no bubble).
  - dreq_gnt_i=1 with idx=NR_WORDS-1: next cycle is IDLE with done_o=1 and ready_o=1.
  - A new save_i is accepted in that done cycle.
- busy_o = (state==STORE); ready_o = !busy_o.
- save_i while busy: ignored (snapshot unchanged); overrun_o set until reset.
- dreq_gnt_i while dreq_valid_o=0: ignored.
- page_offset_match_o (combinational):
  - 1 iff busy and, for some j with idx<=j<NR_WORDS, (next_sp_o + j*WORD_BYTES)[11:3] == page_offset_i[11:3].
  - Already-granted words never match.
- Arithmetic: sp subtraction wraps modulo 2^XLEN; idx is $clog2(NR_WORDS+1) bits.
- No flush input: an accepted save always completes.

Decomposition:
- Shared package holds:
  - shru_state_e {IDLE, STORE}.
  - SHRU_NR_WORDS default constant.
  - Word-index enumeration (MEPC=0, MCAUSE=1, SP=2, RA=3).
- One sub-module is natural: shru_offset_cmp.
  - Parameterised by NR_WORDS.
  - Takes base, idx and page_offset; returns the match bit.
- The FSM, counter and snapshot stay in the top.

Test Plan:
- Basic save, gnt tied high:
  - Stimulus: reset, then save_i at t0 with sp_i=0x8000_1000 and words A,B,C,D.
  - Response: dreq_valid_o t1..t4, addrs 0x8000_0FE0/0FE8/0FF0/0FF8, data A..D, done_o at t5, next_sp_o=0x8000_0FE0 from t1.
- Backpressure:
  - Stimulus: gnt low 3 cycles on word 1.
  - Response: addr 0x..FE8 and data B held stable for all 3 cycles; total save takes 8 cycles; exactly 4 grants consumed.
- Overrun:
  - Stimulus: save_i during STORE.
  - Response: overrun_o=1 sticky; the in-flight save completes with the original data; a second save_i in the done cycle is accepted.
- Offset aliasing:
  - Stimulus: during the save, after word 0 is granted, drive page_offset_i=0xFE0 and then 0xFF0.
  - Response: 0 for 0xFE0 (granted), 1 for 0xFF0; 0 in IDLE.
- Wrap-around:
  - Stimulus: sp_i=0x10 with NR_WORDS=4.
  - Response: next_sp_o=0xFFFF_FFFF_FFFF_FFF0, addrs ...FFF0, ...FFF8, 0x0, 0x8.
- Reset mid-save:
  - Stimulus: assert rst_i after 2 grants.
  - Response: dreq_valid_o drops asynchronously, ready_o=1, done_o never pulses, overrun_o=0.
